// File: rtl/gate_response_checker.sv
// -----------------------------------------------------------------------------
// gate_response_checker
//
// Purpose:
//   Response end for the basic-gate datapath. Each sweep applies the four a/b
//   input combinations (00, 01, 10, 11) to the gate block. After each one it
//   waits a settle time and then samples the seven gate outputs. Each sample
//   is compared against a built-in truth table. The checker accumulates a
//   saturating mismatch-bit count and a sticky per-gate error vector, and
//   reports pass/fail at the end of the sweep.
//
// Parameters:
//   SETTLE_CYCLES  cycles spent in SETTLE after a stimulus change (>= 1)
//   ERR_CNT_W      width of err_count; the count saturates at 2**ERR_CNT_W-1
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   one-cycle sweep request, honoured only in IDLE
//   stim_a     out  gate input a (registered)
//   stim_b     out  gate input b (registered)
//   resp       in   gate outputs {xnor,xor,nor,nand,not(a),or,and}, bit0 = and
//   busy       out  high from the cycle after start is accepted until done
//   done       out  one-cycle pulse at the end of a sweep
//   pass       out  last sweep had zero mismatches; held until the next start
//   err_count  out  mismatching resp bits over the sweep, saturating
//   err_vec    out  sticky OR of mismatching bit positions over the sweep
//   dbg_state  out  current FSM state encoding
//
// Optional feature (macro GATE_CHK_FIRST_FAIL_EN):
//   first_fail_valid / first_fail_ab / first_fail_resp capture the vector and
//   raw resp of the first sample with a nonzero mismatch. All three clear on
//   reset and on an accepted start.
//
// Handshake:
//   start is a level sampled on the rising edge. It is acted on only when the
//   FSM is in IDLE; at any other time it is dropped, with no queueing.
//   done is a one-cycle pulse. pass/err_count/err_vec are valid while done
//   is high and remain stable until the next accepted start.
// -----------------------------------------------------------------------------
module gate_response_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_CNT_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 stim_a,
    output logic                 stim_b,
    input  logic [6:0]           resp,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [6:0]           err_vec,
`ifdef GATE_CHK_FIRST_FAIL_EN
    output logic                 first_fail_valid,
    output logic [1:0]           first_fail_ab,
    output logic [6:0]           first_fail_resp,
`endif
    output logic [2:0]           dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DRIVE  = 3'd1,
        S_SETTLE = 3'd2,
        S_SAMPLE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // Settle counter is loaded with SETTLE_CYCLES-1 and counts down to zero.
    // SETTLE is therefore occupied for exactly SETTLE_CYCLES cycles.
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);

    // The sum is kept wide enough that adding up to 7 never wraps before
    // the saturation compare.
    localparam int SW = ERR_CNT_W + 3;
    localparam logic [SW-1:0] CNT_MAX = SW'((1 << ERR_CNT_W) - 1);

    state_t              state;
    state_t              state_nxt;
    logic [1:0]          idx;
    logic [CW-1:0]       settle_cnt;
    logic [6:0]          exp_resp;
    logic [6:0]          mism;
    logic [2:0]          mism_pop;
    logic [SW-1:0]       cnt_sum;
    logic [ERR_CNT_W-1:0] cnt_nxt;

    assign dbg_state = state;

    // Expected gate outputs for inputs a = v[1], b = v[0].
    function automatic logic [6:0] gate_exp(input logic [1:0] v);
        logic a;
        logic b;
        a = v[1];
        b = v[0];
        gate_exp = {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
    endfunction

    function automatic logic [2:0] popcount7(input logic [6:0] v);
        logic [2:0] c;
        c = 3'd0;
        for (int i = 0; i < 7; i++) begin
            c = c + {2'b00, v[i]};
        end
        popcount7 = c;
    endfunction

    assign exp_resp = gate_exp(idx);
    assign mism     = resp ^ exp_resp;
    assign mism_pop = popcount7(mism);
    assign cnt_sum  = SW'(err_count) + SW'(mism_pop);
    assign cnt_nxt  = (cnt_sum > CNT_MAX) ? {ERR_CNT_W{1'b1}} : cnt_sum[ERR_CNT_W-1:0];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_DRIVE;
            S_DRIVE:  state_nxt = S_SETTLE;
            S_SETTLE: if (settle_cnt == '0) state_nxt = S_SAMPLE;
            S_SAMPLE: state_nxt = (idx == 2'd3) ? S_DONE : S_DRIVE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= 2'd0;
            settle_cnt <= '0;
            stim_a     <= 1'b0;
            stim_b     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            err_vec    <= 7'd0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        err_count <= '0;
                        err_vec   <= 7'd0;
                        pass      <= 1'b0;
                        idx       <= 2'd0;
                        busy      <= 1'b1;
                    end
                end
                S_DRIVE: begin
                    stim_a     <= idx[1];
                    stim_b     <= idx[0];
                    settle_cnt <= SETTLE_LOAD;
                end
                S_SETTLE: begin
                    if (settle_cnt != '0) begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                S_SAMPLE: begin
                    err_vec   <= err_vec | mism;
                    err_count <= cnt_nxt;
                    if (idx != 2'd3) begin
                        idx <= idx + 2'd1;
                    end
                end
                S_DONE: begin
                    done <= 1'b1;
                    // All sampling is complete by now. A saturated count is
                    // still nonzero, so err_vec and err_count agree here.
                    pass <= (err_count == '0) && (err_vec == 7'd0);
                    busy <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

`ifdef GATE_CHK_FIRST_FAIL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_fail_valid <= 1'b0;
            first_fail_ab    <= 2'd0;
            first_fail_resp  <= 7'd0;
        end else begin
            if (state == S_IDLE && start) begin
                first_fail_valid <= 1'b0;
                first_fail_ab    <= 2'd0;
                first_fail_resp  <= 7'd0;
            end else if (state == S_SAMPLE && mism != 7'd0 && !first_fail_valid) begin
                first_fail_valid <= 1'b1;
                first_fail_ab    <= idx;
                first_fail_resp  <= resp;
            end
        end
    end
`endif

endmodule

// File: tb/tb_gate_response_checker.sv
// -----------------------------------------------------------------------------
// tb_gate_response_checker
//
// Bench for gate_response_checker. A behavioural gate block drives resp from
// stim_a/stim_b. A fault mode can corrupt that model. The driver issues
// sweeps and pushes the hand-computed result {pass, err_count, err_vec} into
// exp_q. A monitor pops and compares on every done pulse, and also checks
// done latency.
// -----------------------------------------------------------------------------
module tb_gate_response_checker;

    localparam int W       = 12;
    localparam int LATENCY = 17;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stim_a;
    logic       stim_b;
    logic [6:0] resp;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_count;
    logic [6:0] err_vec;
    logic [2:0] dbg_state;
`ifdef GATE_CHK_FIRST_FAIL_EN
    logic       first_fail_valid;
    logic [1:0] first_fail_ab;
    logic [6:0] first_fail_resp;
`endif

    gate_response_checker #(.SETTLE_CYCLES(2), .ERR_CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stim_a    (stim_a),
        .stim_b    (stim_b),
        .resp      (resp),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .err_vec   (err_vec),
`ifdef GATE_CHK_FIRST_FAIL_EN
        .first_fail_valid (first_fail_valid),
        .first_fail_ab    (first_fail_ab),
        .first_fail_resp  (first_fail_resp),
`endif
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- gate block model with fault injection ----------------
    // mode 0 golden, 1 xor stuck-at-0, 2 all outputs inverted, 3 nand flipped at 11
    int fault_mode = 0;
    logic [6:0] gold;
    always_comb begin
        gold = {~(stim_a ^ stim_b), stim_a ^ stim_b, ~(stim_a | stim_b),
                ~(stim_a & stim_b), ~stim_a, stim_a | stim_b, stim_a & stim_b};
        resp = gold;
        case (fault_mode)
            1: resp = gold & 7'b1011111;
            2: resp = ~gold;
            3: resp = (stim_a && stim_b) ? (gold ^ 7'b0001000) : gold;
            default: resp = gold;
        endcase
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;
    int start_cyc = 0;
    int done_cnt  = 0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: one comparison set per done pulse
    always @(negedge clk) begin
        if (rst_n && done) begin
            logic [W-1:0] e;
            done_cnt++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: done pulse with no pending sweep (cycle %0d)", cyc);
            end else begin
                e = exp_q.pop_front();
                check("pass",      int'(pass),      int'(e[11]));
                check("err_count", int'(err_count), int'(e[10:7]));
                check("err_vec",   int'(err_vec),   int'(e[6:0]));
                check("latency",   cyc - start_cyc, LATENCY);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue_start(input int mode, input bit push,
                               input logic p, input logic [3:0] c, input logic [6:0] v);
        @(negedge clk);
        fault_mode = mode;
        if (push) exp_q.push_back({p, c, v});
        start     = 1'b1;
        start_cyc = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int d0;
        bit seen;
        d0   = done_cnt;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done_cnt != d0) seen = 1'b1;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL done_timeout: no done within 40 cycles (cycle %0d)", cyc);
        end
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int d0;
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_stim",  int'({stim_a, stim_b}), 0);
        check("rst_busy",  int'(busy), 0);
        check("rst_done",  int'(done), 0);
        check("rst_pass",  int'(pass), 0);
        check("rst_cnt",   int'(err_count), 0);
        check("rst_vec",   int'(err_vec), 0);
        check("rst_state", int'(dbg_state), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: golden sweep, also check the stimulus order 00,01,10,11
        issue_start(0, 1'b1, 1'b1, 4'd0, 7'b0000000);
        check("busy_running", int'(busy), 1);
        for (int k = 0; k < 4; k++) begin
            wait_until(start_cyc + 2 + 4 * k);
            check("stim_order", int'({stim_a, stim_b}), k);
        end
        wait_done();
        @(negedge clk);
        check("busy_after", int'(busy), 0);
        check("stim_hold", int'({stim_a, stim_b}), 3);

        // 3: inverted outputs -> 28 bit mismatches, saturated count
        issue_start(2, 1'b1, 1'b0, 4'd15, 7'h7F);
        wait_done();

        // 2: xor stuck-at-0 -> counters cleared by start, then 2 mismatches
        issue_start(1, 1'b1, 1'b0, 4'd2, 7'b0100000);
        wait_done();

        // 4: re-pulses while busy and in DONE are ignored
        d0 = done_cnt;
        issue_start(0, 1'b1, 1'b1, 4'd0, 7'b0000000);
        wait_until(start_cyc + 3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_until(start_cyc + 16);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("single_done", done_cnt - d0, 1);
        check("pass_held",   int'(pass), 1);
        check("idle_after_ignored", int'(dbg_state), 0);

        // 5: reset during vector 10 SETTLE, no done for the aborted sweep
        issue_start(1, 1'b0, 1'b0, 4'd0, 7'd0);
        wait_until(start_cyc + 10);
        check("pre_rst_stim", int'({stim_a, stim_b}), 2);
        check("pre_rst_cnt",  int'(err_count), 1);
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        check("mid_rst_stim", int'({stim_a, stim_b}), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_cnt",  int'(err_count), 0);
        check("mid_rst_vec",  int'(err_vec), 0);
        check("mid_rst_pass", int'(pass), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        check("no_done_after_abort", done_cnt - d0, 0);

`ifdef GATE_CHK_FIRST_FAIL_EN
        // 6: nand flipped at 11 only, first-fail capture
        issue_start(3, 1'b1, 1'b0, 4'd1, 7'b0001000);
        wait_done();
        check("ff_valid", int'(first_fail_valid), 1);
        check("ff_ab",    int'(first_fail_ab), 3);
        check("ff_resp",  int'(first_fail_resp), 7'b1001011);
        issue_start(0, 1'b1, 1'b1, 4'd0, 7'b0000000);
        check("ff_cleared", int'(first_fail_valid), 0);
        wait_done();
        check("ff_stays_clear", int'(first_fail_valid), 0);
`endif

        // Sweep after reset recovery works normally
        issue_start(0, 1'b1, 1'b1, 4'd0, 7'b0000000);
        wait_done();
        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
